// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with KMP failure transitions,
// selectable Mealy/Moore match output, optional overlap and a saturating
// match counter.
module seq_detect_param #(
  parameter int unsigned           PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0]  PATTERN   = 4'b1011,
  parameter bit                    MEALY     = 1'b1,
  parameter bit                    OVERLAP   = 1'b1,
  parameter int unsigned           COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               x,
  input  logic               clear,
  output logic               match,
  output logic [COUNT_W-1:0] match_count
);

  // State = matched prefix length; Moore adds the "matched" state PATTERN_W.
  localparam int unsigned SW = $clog2(PATTERN_W + 1);
  localparam int unsigned NS = MEALY ? PATTERN_W : PATTERN_W + 1;
  localparam int unsigned NT = 2 ** SW;
  localparam int          PW = int'(PATTERN_W);

  // Low-order j ones.
  function automatic logic [31:0] low_mask(input int j);
    logic [31:0] m;
    m = '0;
    if (j > 0) m = 32'hFFFF_FFFF >> (32 - j);
    return m;
  endfunction

  // Pattern in arrival order: bit t holds the t-th bit received.
  function automatic logic [31:0] pat_rev();
    logic [31:0] r;
    r = '0;
    for (int t = 0; t < PW; t++) begin
      r = r | (((32'(PATTERN) >> (PW - 1 - t)) & 32'd1) << t);
    end
    return r;
  endfunction

  // Longest j <= maxj such that the last j bits of seq[len-1:0] equal
  // the first j pattern bits.
  function automatic int longest(input logic [31:0] seq, input int len,
                                 input int maxj);
    int   best;
    int   lim;
    logic found;
    logic [31:0] rev;
    rev   = pat_rev();
    best  = 0;
    found = 1'b0;
    lim   = (len < maxj) ? len : maxj;
    for (int j = lim; j > 0; j--) begin
      if (!found && (((seq >> (len - j)) & low_mask(j)) == (rev & low_mask(j)))) begin
        best  = j;
        found = 1'b1;
      end
    end
    return best;
  endfunction

  // State entered after a completed match.
  function automatic int post_match();
    int p;
    p = 0;
    if (OVERLAP) p = longest(pat_rev(), PW, PW - 1);
    return p;
  endfunction

  // Raw KMP step: result PATTERN_W means the pattern just completed.
  function automatic int raw_next(input int k, input int b);
    int          kk;
    logic [31:0] seq;
    kk  = (k >= PW) ? post_match() : k;
    seq = (pat_rev() & low_mask(kk)) | (32'(b) << kk);
    return longest(seq, kk + 1, PW);
  endfunction

  localparam int unsigned POST = int'(post_match());

  logic [SW-1:0]      raw_tab [NT][2];
  logic [SW-1:0]      state_q;
  logic [SW-1:0]      state_d;
  logic [SW-1:0]      raw_c;
  logic               complete_c;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Elaboration-time transition table indexed by [state][bit].
  for (genvar k = 0; k < int'(NT); k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_col
      localparam int unsigned R = (k < int'(NS)) ? int'(raw_next(k, b)) : 0;
      assign raw_tab[k][b] = SW'(R);
    end
  end

  // Next-state and counter update for an accepted bit.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    raw_c      = raw_tab[state_q][x];
    complete_c = in_valid & (raw_c == SW'(PATTERN_W));
    if (in_valid) begin
      if (MEALY && complete_c) state_d = SW'(POST);
      else                     state_d = raw_c;
    end
    if (complete_c && (count_q != '1)) count_d = count_q + COUNT_W'(1);
  end

  // State and counter registers; reset beats clear beats normal update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      state_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign match_count = count_q;

  // Mealy flags the completing bit combinationally; Moore decodes the matched state.
  if (MEALY) begin : g_mealy
    assign match = in_valid & (state_q == SW'(PATTERN_W - 1)) & (x == PATTERN[0]);
  end else begin : g_moore
    assign match = (state_q == SW'(PATTERN_W));
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: four instances cover Mealy/overlap,
// Mealy/no-overlap, Moore and a 2-bit saturating counter.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0;
  logic x = 1'b0;
  logic clear = 1'b0;

  logic       match_a, match_b, match_c, match_d;
  logic [7:0] count_a, count_b, count_c;
  logic [1:0] count_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b1), .COUNT_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_a), .match_count(count_a));

  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b0), .COUNT_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_b), .match_count(count_b));

  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .MEALY(1'b0), .OVERLAP(1'b1), .COUNT_W(8)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_c), .match_count(count_c));

  seq_detect_param #(.PATTERN_W(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b1), .COUNT_W(2)) u_d (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x(x), .clear(clear),
    .match(match_d), .match_count(count_d));

  // Present one bit at the falling edge; on return Mealy outputs reflect this
  // bit and registered outputs reflect everything before it.
  task automatic apply(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    x        = b;
    clear    = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    x        = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (count_a !== 8'd0) begin failures++; $display("FAIL reset_count_a: got %0d want 0", count_a); end
    checks++;
    if (count_c !== 8'd0) begin failures++; $display("FAIL reset_count_c: got %0d want 0", count_c); end
    checks++;
    if (match_c !== 1'b0) begin failures++; $display("FAIL reset_match_moore: got %b want 0", match_c); end
    checks++;
    if (match_a !== 1'b0) begin failures++; $display("FAIL reset_match_mealy: got %b want 0", match_a); end
    reset_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] stream = 7'b1011011;
    logic [6:0] exp_a  = 7'b0001001;
    logic [6:0] exp_b  = 7'b0001000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, stream[6-i], 1'b0);
      checks++;
      if (match_a !== exp_a[6-i]) begin failures++; $display("FAIL overlap1_match bit%0d: got %b want %b", i+1, match_a, exp_a[6-i]); end
      checks++;
      if (match_b !== exp_b[6-i]) begin failures++; $display("FAIL overlap0_match bit%0d: got %b want %b", i+1, match_b, exp_b[6-i]); end
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd2) begin failures++; $display("FAIL overlap1_count: got %0d want 2", count_a); end
    checks++;
    if (count_b !== 8'd1) begin failures++; $display("FAIL overlap0_count: got %0d want 1", count_b); end
  endtask

  task automatic test_failure_fn();
    logic [4:0] stream = 5'b11011;
    logic [4:0] exp_a  = 5'b00001;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, stream[4-i], 1'b0);
      checks++;
      if (match_a !== exp_a[4-i]) begin failures++; $display("FAIL kmp_match bit%0d: got %b want %b", i+1, match_a, exp_a[4-i]); end
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd1) begin failures++; $display("FAIL kmp_count: got %0d want 1", count_a); end
  endtask

  task automatic test_moore_stall();
    logic [3:0] stream = 4'b1011;
    do_reset();
    for (int i = 0; i < 4; i++) apply(1'b1, stream[3-i], 1'b0);
    checks++;
    if (match_c !== 1'b0) begin failures++; $display("FAIL moore_early: got %b want 0", match_c); end
    for (int s = 0; s < 3; s++) begin
      apply(1'b0, 1'b1, 1'b0);
      checks++;
      if (match_c !== 1'b1) begin failures++; $display("FAIL moore_stall%0d_match: got %b want 1", s, match_c); end
      checks++;
      if (count_c !== 8'd1) begin failures++; $display("FAIL moore_stall%0d_count: got %0d want 1", s, count_c); end
    end
    apply(1'b1, 1'b0, 1'b0);
    checks++;
    if (match_c !== 1'b1) begin failures++; $display("FAIL moore_hold: got %b want 1", match_c); end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (match_c !== 1'b0) begin failures++; $display("FAIL moore_fall: got %b want 0", match_c); end
    checks++;
    if (count_c !== 8'd1) begin failures++; $display("FAIL moore_count: got %0d want 1", count_c); end
  endtask

  task automatic test_mealy_stall();
    do_reset();
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b0);
    checks++;
    if (match_a !== 1'b0) begin failures++; $display("FAIL mealy_stall_low: got %b want 0", match_a); end
    apply(1'b1, 1'b1, 1'b0);
    checks++;
    if (match_a !== 1'b1) begin failures++; $display("FAIL mealy_after_stall: got %b want 1", match_a); end
  endtask

  task automatic test_saturate();
    logic [3:0] pat = 4'b1011;
    int want;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 4; t++) begin
        apply(1'b1, pat[3-t], 1'b0);
        if (t == 0 && r > 0) begin
          want = (r > 3) ? 3 : r;
          checks++;
          if (count_d !== 2'(want)) begin failures++; $display("FAIL sat_count rep%0d: got %0d want %0d", r, count_d, want); end
        end
        if (t == 3) begin
          checks++;
          if (match_d !== 1'b1) begin failures++; $display("FAIL b2b_match rep%0d: got %b want 1", r, match_d); end
        end
      end
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (count_d !== 2'd3) begin failures++; $display("FAIL sat_count final: got %0d want 3", count_d); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    x        = 1'b1;
    #1;
    checks++;
    if (match_a !== 1'b0) begin failures++; $display("FAIL reset_mid_match: got %b want 0", match_a); end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd0) begin failures++; $display("FAIL reset_mid_count: got %0d want 0", count_a); end
  endtask

  task automatic test_clear();
    logic [2:0] tail = 3'b011;
    do_reset();
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, tail[2-i], 1'b0);
      if (i == 0) begin
        checks++;
        if (count_a !== 8'd0) begin failures++; $display("FAIL clear_count: got %0d want 0", count_a); end
        checks++;
        if (match_c !== 1'b0) begin failures++; $display("FAIL clear_moore_match: got %b want 0", match_c); end
      end
      checks++;
      if (match_a !== 1'b0) begin failures++; $display("FAIL clear_state bit%0d: got %b want 0", i, match_a); end
    end
    apply(1'b0, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd0) begin failures++; $display("FAIL clear_count_end: got %0d want 0", count_a); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_failure_fn();
    test_moore_stall();
    test_mealy_stall();
    test_saturate();
    test_reset_mid();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
